// File: rtl/srl_fifo_read_ctrl_pkg.sv
// Shared helpers for the shift-register FIFOs that sit between dataflow PEs.
package srl_fifo_read_ctrl_pkg;

   // Default geometry of a start-token FIFO
   localparam int SRL_FIFO_DEF_DEPTH = 3;

   // Total words held: shift-register entries plus the output register
   function automatic int fifo_capacity(input int depth);
      return depth + 1;
   endfunction

   // Smallest width w (at least 1) with 2**w >= n
   function automatic int fifo_addr_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/srl_fifo_read_ctrl_if.sv
// Producer/consumer handshake bundle of a shift-register FIFO.
interface srl_fifo_read_ctrl_if #(
   parameter int DATA_WIDTH = 1
);
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;

   // FIFO side
   modport slave (
      input  if_write, if_din, if_read,
      output if_full_n, if_dout, if_empty_n
   );

   // Producer/consumer side
   modport master (
      output if_write, if_din, if_read,
      input  if_full_n, if_dout, if_empty_n
   );
endinterface

// File: rtl/srl_fifo_storage.sv
// Plain shift-register array: new words enter at index 0, oldest sits at the
// highest occupied index. No reset; contents are qualified by the controller.
module srl_fifo_storage #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = 3
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Shift every entry up by one on a write
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   // Combinational read of the pre-shift contents
   always_comb begin
      dout_o = '0;
      if (int'(addr_i) < DEPTH) begin
         dout_o = mem_q[addr_i];
      end
   end

endmodule

// File: rtl/srl_fifo_read_ctrl.sv
// Read-side controller for a shift-register FIFO with a registered
// first-word-fall-through output. Capacity is DEPTH+1 words.
module srl_fifo_read_ctrl
   import srl_fifo_read_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = SRL_FIFO_DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   srl_fifo_read_ctrl_if.slave   fifo
);

   // Counter must hold 0..DEPTH
   localparam int CNT_W = fifo_addr_width(fifo_capacity(DEPTH));

   logic [CNT_W-1:0]      srl_cnt_q, srl_cnt_d;
   logic                  out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0] dout_q,    dout_d;
   logic                  full_n_q,  full_n_d;

   logic                  push, pop, slot, cnt_zero, bypass, load, srl_we;
   logic [ADDR_WIDTH-1:0] srl_addr;
   logic [DATA_WIDTH-1:0] srl_dout;

   srl_fifo_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_storage (
      .clk    (clk),
      .we_i   (srl_we),
      .addr_i (srl_addr),
      .din_i  (fifo.if_din),
      .dout_o (srl_dout)
   );

   // Handshake decode, storage control and next-state computation
   always_comb begin
      push     = fifo.if_write & full_n_q;
      pop      = fifo.if_read & out_vld_q;
      slot     = ~out_vld_q | pop;
      cnt_zero = (srl_cnt_q == '0);
      // Empty storage and a free output slot: skip the shift register
      bypass   = push & slot & cnt_zero;
      // Oldest stored word refills the output register, read before any shift
      load     = slot & ~cnt_zero;
      srl_we   = push & ~bypass;
      srl_addr = cnt_zero ? '0 : ADDR_WIDTH'(srl_cnt_q - CNT_W'(1));

      srl_cnt_d = srl_cnt_q + CNT_W'(srl_we) - CNT_W'(load);
      out_vld_d = load | bypass | (out_vld_q & ~pop);
      dout_d    = dout_q;
      if (bypass) begin
         dout_d = fifo.if_din;
      end else if (load) begin
         dout_d = srl_dout;
      end
      // Registered full flag derived from the next occupancy
      full_n_d = (int'(srl_cnt_d) < DEPTH);
   end

   // State register; all words dropped on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         srl_cnt_q <= '0;
         out_vld_q <= 1'b0;
         dout_q    <= '0;
         full_n_q  <= 1'b1;
      end else begin
         srl_cnt_q <= srl_cnt_d;
         out_vld_q <= out_vld_d;
         dout_q    <= dout_d;
         full_n_q  <= full_n_d;
      end
   end

   assign fifo.if_full_n  = full_n_q;
   assign fifo.if_empty_n = out_vld_q;
   assign fifo.if_dout    = dout_q;

endmodule
